// File: rtl/postfix_eval.sv
// postfix_eval
//   Evaluates a reverse-Polish token stream on an internal signed operand stack
//   and emits one result per expression. Numbers arrive on NUMBER_*, operators
//   ('+' '-' '*' '/') on SIGN_*. Both strobes in the same cycle mark the end of
//   the expression. Division is a restoring divider that produces one quotient
//   bit per cycle.
//
// Ports
//   CLK         in   clock, rising edge
//   RST         in   asynchronous active-low reset
//   NUMBER_IN   in   8-bit unsigned operand, zero-extended to W
//   NUMBER_STB  in   NUMBER_IN valid (single-cycle pulse)
//   SIGN_IN     in   ASCII operator code
//   SIGN_STB    in   SIGN_IN valid (single-cycle pulse)
//   BUSY        out  operator or end marker executing
//   RESULT      out  last evaluated value, held between RESULT_STB pulses
//   RESULT_STB  out  one-cycle pulse, RESULT valid
//   ERR_CODE    out  last error code (1 underflow, 2 overflow, 3 divide by zero,
//                    4 bad operator, 5 overrun, 6 bad end depth)
//   ERR_STB     out  one-cycle pulse when an error is detected
//   DEPTH_OUT   out  current operand count
module postfix_eval #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [7:0]                 NUMBER_IN,
    input  logic                       NUMBER_STB,
    input  logic [7:0]                 SIGN_IN,
    input  logic                       SIGN_STB,
    output logic                       BUSY,
    output logic [W-1:0]               RESULT,
    output logic                       RESULT_STB,
    output logic [2:0]                 ERR_CODE,
    output logic                       ERR_STB,
    output logic [$clog2(DEPTH+1)-1:0] DEPTH_OUT
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {S_ACCEPT, S_ALU, S_DIV, S_DONE, S_ERR} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_stack [DEPTH];
    logic [DW-1:0] r_depth;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    op_t           r_op;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_dvs;
    logic          r_neg;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_result;
    logic [2:0]    r_err_code;
    logic          r_err_stb;

    // Operator decode
    op_t  w_op;
    logic w_op_ok;

    always_comb begin
        w_op    = OP_ADD;
        w_op_ok = 1'b1;
        case (SIGN_IN)
            8'd43:   w_op = OP_ADD;
            8'd45:   w_op = OP_SUB;
            8'd42:   w_op = OP_MUL;
            8'd47:   w_op = OP_DIV;
            default: w_op_ok = 1'b0;
        endcase
    end

    // Stack addressing; indices are only used when the depth makes them valid
    logic [IW-1:0] w_top_idx;
    logic [IW-1:0] w_sec_idx;
    logic [IW-1:0] w_push_idx;
    logic [W-1:0]  w_top;
    logic [W-1:0]  w_sec;

    assign w_top_idx  = IW'(r_depth - DW'(1));
    assign w_sec_idx  = IW'(r_depth - DW'(2));
    assign w_push_idx = IW'(r_depth);
    assign w_top      = r_stack[w_top_idx];
    assign w_sec      = r_stack[w_sec_idx];

    // Single-cycle operators; all wrap to the low W bits
    logic [W-1:0] w_alu;

    always_comb begin
        case (r_op)
            OP_SUB:  w_alu = r_a - r_b;
            OP_MUL:  w_alu = r_a * r_b;
            default: w_alu = r_a + r_b;
        endcase
    end

    // Restoring divider on magnitudes. |MIN| = 2^(W-1) still fits unsigned in
    // W bits, and the partial remainder stays below the divisor, so the shifted
    // remainder never needs more than W+1 bits.
    logic [W-1:0] w_abs_a;
    logic [W-1:0] w_abs_b;
    logic [W:0]   w_rem_sh;
    logic [W:0]   w_diff;
    logic         w_ge;
    logic [W-1:0] w_rem_nx;
    logic [W-1:0] w_quo_nx;
    logic [W-1:0] w_div_res;

    assign w_abs_a   = r_a[W-1] ? -r_a : r_a;
    assign w_abs_b   = r_b[W-1] ? -r_b : r_b;
    assign w_rem_sh  = {r_rem, r_quo[W-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[W];
    assign w_rem_nx  = w_ge ? w_diff[W-1:0] : w_rem_sh[W-1:0];
    assign w_quo_nx  = {r_quo[W-2:0], w_ge};
    // MIN / -1 yields magnitude 2^(W-1) with no negation, i.e. MIN again
    assign w_div_res = r_neg ? -w_quo_nx : w_quo_nx;

    // Control
    logic       w_any_stb;
    logic       w_end;
    logic       w_err_set;
    logic [2:0] w_err_code;
    logic       w_push;
    logic       w_wr_alu;
    logic       w_wr_div;
    logic       w_clear;
    logic       w_latch;
    logic       w_div_init;
    logic       w_div_step;
    logic       w_res_load;

    assign w_any_stb = NUMBER_STB | SIGN_STB;
    assign w_end     = NUMBER_STB & SIGN_STB;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_ACCEPT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err_set  = 1'b0;
        w_err_code = 3'd0;
        w_push     = 1'b0;
        w_wr_alu   = 1'b0;
        w_wr_div   = 1'b0;
        w_clear    = 1'b0;
        w_latch    = 1'b0;
        w_div_init = 1'b0;
        w_div_step = 1'b0;
        w_res_load = 1'b0;
        case (r_state)
            S_ACCEPT: begin
                if (w_end) begin
                    if (r_depth == DW'(1)) begin
                        w_res_load = 1'b1;
                        w_next     = S_DONE;
                    end else begin
                        // End marker already consumed: report and restart directly
                        w_err_set  = 1'b1;
                        w_err_code = 3'd6;
                        w_clear    = 1'b1;
                        w_next     = S_ACCEPT;
                    end
                end else if (NUMBER_STB) begin
                    if (r_depth == DW'(DEPTH)) begin
                        w_err_set  = 1'b1;
                        w_err_code = 3'd2;
                        w_next     = S_ERR;
                    end else begin
                        w_push = 1'b1;
                    end
                end else if (SIGN_STB) begin
                    if (!w_op_ok) begin
                        w_err_set  = 1'b1;
                        w_err_code = 3'd4;
                        w_next     = S_ERR;
                    end else if (r_depth < DW'(2)) begin
                        w_err_set  = 1'b1;
                        w_err_code = 3'd1;
                        w_next     = S_ERR;
                    end else begin
                        w_latch = 1'b1;
                        w_next  = (w_op == OP_DIV) ? S_DIV : S_ALU;
                    end
                end
            end
            S_ALU: begin
                if (w_any_stb) begin
                    w_err_set  = 1'b1;
                    w_err_code = 3'd5;
                    w_next     = S_ERR;
                end else begin
                    w_wr_alu = 1'b1;
                    w_next   = S_ACCEPT;
                end
            end
            S_DIV: begin
                if (w_any_stb) begin
                    w_err_set  = 1'b1;
                    w_err_code = 3'd5;
                    w_next     = S_ERR;
                end else if (r_cnt == '0) begin
                    if (r_b == '0) begin
                        w_err_set  = 1'b1;
                        w_err_code = 3'd3;
                        w_next     = S_ERR;
                    end else begin
                        w_div_init = 1'b1;
                    end
                end else begin
                    w_div_step = 1'b1;
                    if (r_cnt == CW'(W)) begin
                        w_wr_div = 1'b1;
                        w_next   = S_ACCEPT;
                    end
                end
            end
            S_DONE: begin
                if (w_any_stb) begin
                    w_err_set  = 1'b1;
                    w_err_code = 3'd5;
                    w_next     = S_ERR;
                end else begin
                    w_clear = 1'b1;
                    w_next  = S_ACCEPT;
                end
            end
            S_ERR: begin
                if (w_end) begin
                    w_clear = 1'b1;
                    w_next  = S_ACCEPT;
                end
            end
            default: w_next = S_ACCEPT;
        endcase
    end

    // Datapath
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
            r_depth    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_ADD;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_neg      <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_err_code <= '0;
            r_err_stb  <= 1'b0;
        end else begin
            if (w_clear) begin
                r_depth <= '0;
            end else if (w_push) begin
                r_stack[w_push_idx] <= W'(NUMBER_IN);
                r_depth             <= r_depth + DW'(1);
            end else if (w_wr_alu) begin
                r_stack[w_sec_idx] <= w_alu;
                r_depth            <= r_depth - DW'(1);
            end else if (w_wr_div) begin
                r_stack[w_sec_idx] <= w_div_res;
                r_depth            <= r_depth - DW'(1);
            end

            if (w_latch) begin
                r_a   <= w_sec;
                r_b   <= w_top;
                r_op  <= w_op;
                r_cnt <= '0;
            end

            if (w_div_init) begin
                r_rem <= '0;
                r_quo <= w_abs_a;
                r_dvs <= w_abs_b;
                r_neg <= r_a[W-1] ^ r_b[W-1];
                r_cnt <= CW'(1);
            end else if (w_div_step) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_res_load) begin
                r_result <= w_top;
            end

            if (w_err_set) begin
                r_err_code <= w_err_code;
            end
            r_err_stb <= w_err_set;
        end
    end

    // RESULT is loaded on entry to DONE, so the strobe is simply the DONE state
    assign BUSY       = (r_state == S_ALU) || (r_state == S_DIV) || (r_state == S_DONE);
    assign RESULT     = r_result;
    assign RESULT_STB = (r_state == S_DONE);
    assign ERR_CODE   = r_err_code;
    assign ERR_STB    = r_err_stb;
    assign DEPTH_OUT  = r_depth;

endmodule
